// File: rtl/dout_pkg.sv
// Shared types and defaults for the ADC dout transmit path.
package dout_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_DRDY, ST_SHIFT, ST_GAP} state_t;

   localparam int DATA_W_DEF = 24;
   localparam int N_CH       = 2;
   localparam int FRAME_BITS = N_CH * DATA_W_DEF;

endpackage

// File: rtl/dclk_gen.sv
// Half-period timer for dclk: strobes every CLK_DIV cycles while enabled and
// holds the registered dclk level. Counter and level clear when disabled.
module dclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic i_en,
   input  logic i_tgl_en,
   output logic o_half_tick,
   output logic o_dclk
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_dclk;

   assign o_half_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));
   assign o_dclk      = r_dclk;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_cnt  <= '0;
         r_dclk <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_dclk <= 1'b0;
      end else begin
         r_cnt <= o_half_tick ? '0 : r_cnt + 1'b1;
         if (o_half_tick && i_tgl_en)
            r_dclk <= ~r_dclk;
      end
   end

endmodule

// File: rtl/dout_writer.sv
// ADC-style serial transmitter: drdy strobe, then ch1/ch2 shifted MSB first on
// dclk, then an idle gap before the next start is accepted.
module dout_writer
   import dout_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int GAP_CYCLES = 8
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic [DATA_W-1:0] ch1_i,
   input  logic [DATA_W-1:0] ch2_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              overrun_o,
   output logic              drdy_o,
   output logic              dclk_o,
   output logic              dout_o
);

   localparam int FB = N_CH * DATA_W;
   localparam int BW = $clog2(FB);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   state_t        r_state;
   logic [FB-1:0] r_sr;
   logic [BW-1:0] r_bit_cnt;
   logic [GW-1:0] r_gap_cnt;
   logic          r_drdy_half;
   logic          r_busy, r_done, r_ovr, r_drdy;

   logic w_half_tick, w_dclk, w_en, w_tgl_en, w_last;

   assign w_last = (r_bit_cnt == BW'(FB - 1));
   assign w_en   = (r_state == ST_DRDY) || (r_state == ST_SHIFT);
   // dclk rises as DRDY ends; it must not rise again after the last low half.
   assign w_tgl_en = ((r_state == ST_DRDY) && r_drdy_half) ||
                     ((r_state == ST_SHIFT) && !(w_last && !w_dclk));

   dclk_gen #(.CLK_DIV(CLK_DIV)) u_dclk_gen (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .i_en        (w_en),
      .i_tgl_en    (w_tgl_en),
      .o_half_tick (w_half_tick),
      .o_dclk      (w_dclk)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state     <= ST_IDLE;
         r_sr        <= '0;
         r_bit_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_drdy_half <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ovr       <= 1'b0;
         r_drdy      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_ovr  <= start_i && r_busy;
         case (r_state)
            ST_IDLE: if (start_i) begin
               r_sr        <= {ch1_i, ch2_i};
               r_bit_cnt   <= '0;
               r_drdy_half <= 1'b0;
               r_busy      <= 1'b1;
               r_drdy      <= 1'b1;
               r_state     <= ST_DRDY;
            end
            ST_DRDY: if (w_half_tick) begin
               if (r_drdy_half) begin
                  r_drdy  <= 1'b0;
                  r_state <= ST_SHIFT;
               end else begin
                  r_drdy_half <= 1'b1;
               end
            end
            ST_SHIFT: if (w_half_tick) begin
               // Data moves on the falling half; the bit index advances at period end.
               if (w_dclk) begin
                  if (!w_last)
                     r_sr <= {r_sr[FB-2:0], 1'b0};
               end else if (w_last) begin
                  r_sr      <= '0;
                  r_gap_cnt <= '0;
                  r_done    <= 1'b1;
                  r_state   <= ST_GAP;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign overrun_o = r_ovr;
   assign drdy_o    = r_drdy;
   assign dclk_o    = w_dclk;
   assign dout_o    = r_sr[FB-1];

endmodule

// File: tb/tb_dout_writer.sv
// Directed bench for dout_writer: default instance plus a CLK_DIV=1, DATA_W=8 instance.
module tb_dout_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        a_start, b_start;
   logic [23:0] a_ch1, a_ch2;
   logic [7:0]  b_ch1, b_ch2;
   logic a_busy, a_done, a_ovr, a_drdy, a_dclk, a_dout;
   logic b_busy, b_done, b_ovr, b_drdy, b_dclk, b_dout;

   dout_writer u_a (
      .clk_i(clk), .reset_ni(rst_n), .start_i(a_start), .ch1_i(a_ch1), .ch2_i(a_ch2),
      .busy_o(a_busy), .done_o(a_done), .overrun_o(a_ovr), .drdy_o(a_drdy),
      .dclk_o(a_dclk), .dout_o(a_dout)
   );

   dout_writer #(.CLK_DIV(1), .DATA_W(8), .GAP_CYCLES(8)) u_b (
      .clk_i(clk), .reset_ni(rst_n), .start_i(b_start), .ch1_i(b_ch1), .ch2_i(b_ch2),
      .busy_o(b_busy), .done_o(b_done), .overrun_o(b_ovr), .drdy_o(b_drdy),
      .dclk_o(b_dclk), .dout_o(b_dout)
   );

   int n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Per-instance frame monitors; cycle numbers are relative to the start edge.
   int ncyc = 0;
   int a_s, a_drdy_cnt, a_drdy_first, a_drdy_last, a_nrise, a_hi, a_done_rel, a_busy_last, a_ovr_cnt;
   int b_s, b_drdy_cnt, b_drdy_first, b_nrise, b_hi, b_done_rel, b_busy_last;
   logic [47:0] a_bits;
   logic [15:0] b_bits;
   logic a_pdclk = 1'b0, b_pdclk = 1'b0;

   always @(negedge clk) begin
      ncyc++;
      if (a_drdy) begin
         a_drdy_cnt++;
         if (a_drdy_first < 0) a_drdy_first = ncyc - a_s - 1;
         a_drdy_last = ncyc - a_s - 1;
      end
      if (a_dclk && !a_pdclk) begin a_bits = {a_bits[46:0], a_dout}; a_nrise++; end
      if (a_dclk) a_hi++;
      a_pdclk = a_dclk;
      if (a_done) a_done_rel = ncyc - a_s - 1;
      if (a_busy) a_busy_last = ncyc - a_s - 1;
      if (a_ovr) a_ovr_cnt++;
      if (b_drdy) begin
         b_drdy_cnt++;
         if (b_drdy_first < 0) b_drdy_first = ncyc - b_s - 1;
      end
      if (b_dclk && !b_pdclk) begin b_bits = {b_bits[14:0], b_dout}; b_nrise++; end
      if (b_dclk) b_hi++;
      b_pdclk = b_dclk;
      if (b_done) b_done_rel = ncyc - b_s - 1;
      if (b_busy) b_busy_last = ncyc - b_s - 1;
   end

   task automatic a_start_now(input logic [23:0] c1, input logic [23:0] c2);
      a_s = ncyc; a_drdy_cnt = 0; a_drdy_first = -1; a_drdy_last = -1; a_nrise = 0; a_hi = 0;
      a_done_rel = -1; a_busy_last = -1; a_ovr_cnt = 0; a_bits = '0;
      a_ch1 = c1; a_ch2 = c2; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0; a_ch1 = 24'h5A5A5A; a_ch2 = 24'hC3C3C3;
   endtask

   task automatic a_frame(input logic [23:0] c1, input logic [23:0] c2);
      @(posedge clk); #1;
      a_start_now(c1, c2);
   endtask

   task automatic a_wait_idle();
      int k = 0;
      do begin @(posedge clk); #1; k++; end while (a_busy && k < 2000);
      check("a_idle_timeout", {63'd0, a_busy}, 64'd0);
   endtask

   task automatic a_check_frame(input string tag, input logic [47:0] exp_bits, input int exp_ovr);
      check({tag, "_drdy_first"}, 64'(a_drdy_first), 64'd1);
      check({tag, "_drdy_last"},  64'(a_drdy_last),  64'd8);
      check({tag, "_drdy_cnt"},   64'(a_drdy_cnt),   64'd8);
      check({tag, "_nrise"},      64'(a_nrise),      64'd48);
      check({tag, "_dclk_hi"},    64'(a_hi),         64'd192);
      check({tag, "_bits"},       {16'd0, a_bits},   {16'd0, exp_bits});
      check({tag, "_done_cyc"},   64'(a_done_rel),   64'd393);
      check({tag, "_busy_last"},  64'(a_busy_last),  64'd400);
      check({tag, "_ovr_cnt"},    64'(a_ovr_cnt),    64'(exp_ovr));
   endtask

   initial begin
      logic [23:0] r1, r2;
      int k;
      logic acc;
      a_start = 1'b0; b_start = 1'b0;
      a_ch1 = '0; a_ch2 = '0; b_ch1 = '0; b_ch2 = '0;
      a_s = 0; b_s = 0; a_drdy_first = -1; b_drdy_first = -1;
      rst_n = 1'b0;
      #1;
      check("reset_a_outs", {58'd0, a_busy, a_done, a_ovr, a_drdy, a_dclk, a_dout}, 64'd0);
      check("reset_b_outs", {58'd0, b_busy, b_done, b_ovr, b_drdy, b_dclk, b_dout}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single frame with extreme-sign words.
      a_frame(24'h800001, 24'h7FFFFF);
      a_wait_idle();
      a_check_frame("single", {24'h800001, 24'h7FFFFF}, 0);

      // Starts at cycle 50 and in the done cycle are dropped.
      a_frame(24'h800001, 24'h7FFFFF);
      repeat (49) @(posedge clk);
      #1 a_start = 1'b1; a_ch1 = 24'h123456; a_ch2 = 24'h654321;
      @(posedge clk); #1 a_start = 1'b0;
      repeat (342) @(posedge clk);
      #1 a_start = 1'b1;
      check("ovr_done_seen", {63'd0, a_done}, 64'd1);
      @(posedge clk); #1 a_start = 1'b0;
      a_wait_idle();
      a_check_frame("overrun", {24'h800001, 24'h7FFFFF}, 2);

      // Back-to-back: start in the first cycle busy is low.
      a_frame(24'hFFFFFF, 24'h000000);
      a_wait_idle();
      a_check_frame("b2b_first", {24'hFFFFFF, 24'h000000}, 0);
      a_start_now(24'h0F0F0F, 24'hABCDEF);
      a_wait_idle();
      a_check_frame("b2b_second", {24'h0F0F0F, 24'hABCDEF}, 0);

      // Fast instance: dclk toggles every cycle.
      @(posedge clk); #1;
      b_s = ncyc; b_drdy_cnt = 0; b_drdy_first = -1; b_nrise = 0; b_hi = 0;
      b_done_rel = -1; b_busy_last = -1; b_bits = '0;
      b_ch1 = 8'hA5; b_ch2 = 8'h3C; b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0; b_ch1 = 8'h00; b_ch2 = 8'hFF;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (b_busy && k < 200);
      check("b_idle_timeout", {63'd0, b_busy}, 64'd0);
      check("b_drdy_first", 64'(b_drdy_first), 64'd1);
      check("b_drdy_cnt",   64'(b_drdy_cnt),   64'd2);
      check("b_nrise",      64'(b_nrise),      64'd16);
      check("b_dclk_hi",    64'(b_hi),         64'd16);
      check("b_bits",       {48'd0, b_bits},   {48'd0, 16'hA53C});
      check("b_done_cyc",   64'(b_done_rel),   64'd35);
      check("b_busy_last",  64'(b_busy_last),  64'd42);

      // Random words.
      for (int i = 0; i < 5; i++) begin
         r1 = 24'($urandom); r2 = 24'($urandom);
         a_frame(r1, r2);
         a_wait_idle();
         check("rand_bits", {16'd0, a_bits}, {16'd0, r1, r2});
         check("rand_nrise", 64'(a_nrise), 64'd48);
      end

      // Reset in the middle of SHIFT abandons the frame immediately.
      a_frame(24'hFFFFFF, 24'hFFFFFF);
      repeat (100) @(posedge clk);
      #1;
      check("mid_busy", {63'd0, a_busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_outs", {58'd0, a_busy, a_done, a_ovr, a_drdy, a_dclk, a_dout}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      acc = 1'b0;
      repeat (100) begin
         @(negedge clk);
         acc = acc | a_busy | a_done | a_ovr | a_drdy | a_dclk | a_dout;
      end
      check("post_reset_quiet", {63'd0, acc}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
